// File: rtl/tlul_req_limiter.sv
// tlul_req_limiter
//   Caps the number of outstanding TL-UL A-channel requests at MaxOut and
//   checks that D-channel responses come back in request order. The block
//   only observes the D channel: every beat is forwarded unchanged, and
//   anomalies raise sticky flags.
//
//   top_pkg / tlul_pkg: minimal TL-UL type definitions used by the ports.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   tl_h_i, tl_h_o  host side (request in, response out)
//   tl_d_o, tl_d_i  device side (request out, response in)
//   outstanding_o   count of accepted requests still awaiting a response
//   order_err_o     sticky: response source mismatch, or response with nothing outstanding
//   timeout_o       sticky: D-channel idle too long while requests are outstanding
//
// Build option
//   TLUL_REQ_LIMITER_TIMEOUT_EN  when defined, adds a 16-bit idle counter that
//                                drives timeout_o; otherwise timeout_o is 0.

package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
endpackage

package tlul_pkg;
    typedef struct packed {
        logic                       a_valid;
        logic [2:0]                 a_opcode;
        logic [2:0]                 a_param;
        logic [top_pkg::TL_SZW-1:0] a_size;
        logic [top_pkg::TL_AIW-1:0] a_source;
        logic [top_pkg::TL_AW-1:0]  a_address;
        logic [top_pkg::TL_DBW-1:0] a_mask;
        logic [top_pkg::TL_DW-1:0]  a_data;
        logic                       d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                       d_valid;
        logic [2:0]                 d_opcode;
        logic [2:0]                 d_param;
        logic [top_pkg::TL_SZW-1:0] d_size;
        logic [top_pkg::TL_AIW-1:0] d_source;
        logic [top_pkg::TL_DIW-1:0] d_sink;
        logic [top_pkg::TL_DW-1:0]  d_data;
        logic                       d_error;
        logic                       a_ready;
    } tl_d2h_t;
endpackage

module tlul_req_limiter #(
    parameter int unsigned MaxOut        = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  tlul_pkg::tl_h2d_t               tl_h_i,
    output tlul_pkg::tl_d2h_t               tl_h_o,
    output tlul_pkg::tl_h2d_t               tl_d_o,
    input  tlul_pkg::tl_d2h_t               tl_d_i,
    output logic [$clog2(MaxOut+1)-1:0]     outstanding_o,
    output logic                            order_err_o,
    output logic                            timeout_o
);

    localparam int unsigned CntW = $clog2(MaxOut + 1);
    localparam int unsigned PtrW = (MaxOut > 1) ? $clog2(MaxOut) : 1;
    localparam int unsigned AIW  = top_pkg::TL_AIW;

    logic                       full;
    logic                       a_acc;
    logic                       d_acc;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;

    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [MaxOut-1:0][AIW-1:0] mem_q, mem_d;
    logic                       order_err_q, order_err_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOut - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Counter is held at 0 by the async reset, so full is 0 during reset.
    assign full       = (cnt_q == CntW'(MaxOut));
    assign fifo_empty = (cnt_q == '0);
    assign a_acc      = tl_h_i.a_valid & ~full & tl_d_i.a_ready;
    assign d_acc      = tl_d_i.d_valid & tl_h_i.d_ready;

    // A response arriving with nothing tracked, in the same cycle as a new
    // request, is taken to consume that request: neither push nor pop, so
    // the counter stays put and FIFO occupancy keeps matching it.
    assign pop  = d_acc & ~fifo_empty;
    assign push = a_acc & ~(d_acc & fifo_empty);

    always_comb begin
        tl_d_o         = tl_h_i;
        tl_d_o.a_valid = tl_h_i.a_valid & ~full;
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = tl_d_i.a_ready & ~full;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = tl_h_i.a_source;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        order_err_d = order_err_q
                    | (d_acc & (fifo_empty | (tl_d_i.d_source != mem_q[rd_ptr_q])));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '0;
            order_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            order_err_q <= order_err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign order_err_o   = order_err_q;

`ifdef TLUL_REQ_LIMITER_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        idle_d    = (d_acc || fifo_empty) ? 16'd0 : idle_q + 16'd1;
        timeout_d = timeout_q | (idle_d == 16'(TimeoutCycles - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_tlul_req_limiter.sv
// Directed bench for tlul_req_limiter (MaxOut=4, TimeoutCycles=8).
// Stimulus pushes expected A beats (device side) and D beats (host side)
// into queues; a negedge monitor pops and compares whenever a beat is
// accepted. Counter and flag values are checked directly from the stimulus.
module tb_tlul_req_limiter;

`ifdef TLUL_REQ_LIMITER_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    tlul_pkg::tl_h2d_t h_req;
    tlul_pkg::tl_d2h_t h_rsp;
    tlul_pkg::tl_h2d_t d_req;
    tlul_pkg::tl_d2h_t d_rsp;
    logic [2:0]        outstanding;
    logic              order_err;
    logic              timeout;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] exp_a[$];
    logic [39:0] exp_d[$];

    always #5 clk = ~clk;

    tlul_req_limiter #(.MaxOut(4), .TimeoutCycles(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tl_h_i       (h_req),
        .tl_h_o       (h_rsp),
        .tl_d_o       (d_req),
        .tl_d_i       (d_rsp),
        .outstanding_o(outstanding),
        .order_err_o  (order_err),
        .timeout_o    (timeout)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [7:0] src, input logic accept);
        h_req.a_valid   = v;
        h_req.a_source  = src;
        h_req.a_address = {20'h0, src, 4'h0};
        if (v && accept) exp_a.push_back({src, 20'h0, src, 4'h0});
    endtask

    task automatic drv_d(input logic v, input logic [7:0] src, input logic [31:0] data);
        d_rsp.d_valid  = v;
        d_rsp.d_source = src;
        d_rsp.d_data   = data;
        if (v && h_req.d_ready) exp_d.push_back({src, data});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv_a(1'b0, 8'h0, 1'b0);
        drv_d(1'b0, 8'h0, 32'h0);
        cyc();
        chk("rst_cnt", 64'(outstanding), 0);
        chk("rst_order_err", 64'(order_err), 0);
        chk("rst_timeout", 64'(timeout), 0);
        rst_n = 1'b1;
        cyc();
    endtask

    // Scoreboard monitor: compares every accepted beat against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (d_req.a_valid && d_rsp.a_ready) begin
                if (exp_a.size() == 0) chk("a_unexpected_beat", 1, 0);
                else chk("a_beat", {d_req.a_source, d_req.a_address}, exp_a.pop_front());
            end
            if (h_rsp.d_valid && h_req.d_ready) begin
                if (exp_d.size() == 0) chk("d_unexpected_beat", 1, 0);
                else chk("d_beat", {h_rsp.d_source, h_rsp.d_data}, exp_d.pop_front());
            end
        end
    end

    initial begin
        h_req = '0;
        d_rsp = '0;
        rst_n = 1'b0;
        d_rsp.a_ready = 1'b1;
        h_req.d_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Paths stay combinational during reset with full deasserted.
        h_req.a_valid = 1'b1;
        #1;
        chk("rst_cnt0", 64'(outstanding), 0);
        chk("rst_order_err0", 64'(order_err), 0);
        chk("rst_timeout0", 64'(timeout), 0);
        chk("rst_pass_a_ready", 64'(h_rsp.a_ready), 1);
        chk("rst_pass_a_valid", 64'(d_req.a_valid), 1);
        cyc();
        chk("rst_cnt_held", 64'(outstanding), 0);
        h_req.a_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Six back-to-back requests: four pass, then the limiter closes.
        for (int i = 0; i < 6; i++) begin
            drv_a(1'b1, 8'(i + 1), i < 4);
            #1;
            chk((i < 4) ? "a_ready_open" : "a_ready_full", 64'(h_rsp.a_ready), (i < 4) ? 1 : 0);
            chk((i < 4) ? "a_valid_open" : "a_valid_full", 64'(d_req.a_valid), (i < 4) ? 1 : 0);
            cyc();
        end
        chk("cnt_full", 64'(outstanding), 4);

        // Response held off by host d_ready: nothing retires.
        h_req.d_ready = 1'b0;
        drv_d(1'b1, 8'h1, 32'hA1);
        cyc();
        chk("cnt_no_d_ready", 64'(outstanding), 4);
        h_req.d_ready = 1'b1;

        // Full: matching response retires one; the waiting request passes next cycle.
        drv_a(1'b1, 8'h5, 1'b0);
        drv_d(1'b1, 8'h1, 32'hA1);
        #1;
        chk("a_ready_full_resp", 64'(h_rsp.a_ready), 0);
        cyc();
        chk("cnt_after_resp", 64'(outstanding), 3);
        drv_d(1'b0, 8'h0, 32'h0);
        drv_a(1'b1, 8'h5, 1'b1);
        #1;
        chk("a_ready_reopen", 64'(h_rsp.a_ready), 1);
        cyc();
        drv_a(1'b0, 8'h0, 1'b0);
        chk("cnt_refill", 64'(outstanding), 4);

        // Drain to two: FIFO holds 4, 5.
        drv_d(1'b1, 8'h2, 32'hB2);
        cyc();
        drv_d(1'b1, 8'h3, 32'hB3);
        cyc();
        drv_d(1'b0, 8'h0, 32'h0);
        chk("cnt_two", 64'(outstanding), 2);

        // Simultaneous request and response at count 2.
        drv_a(1'b1, 8'h6, 1'b1);
        drv_d(1'b1, 8'h4, 32'hC4);
        cyc();
        drv_a(1'b0, 8'h0, 1'b0);
        chk("cnt_simul", 64'(outstanding), 2);
        chk("order_ok_simul", 64'(order_err), 0);
        drv_d(1'b1, 8'h5, 32'hC5);
        cyc();
        drv_d(1'b1, 8'h6, 32'hC6);
        cyc();
        drv_d(1'b0, 8'h0, 32'h0);
        chk("cnt_drained", 64'(outstanding), 0);
        chk("order_ok_drained", 64'(order_err), 0);

        // Out-of-order response: flag set, entry still popped.
        drv_a(1'b1, 8'h1, 1'b1);
        cyc();
        drv_a(1'b1, 8'h2, 1'b1);
        cyc();
        drv_a(1'b0, 8'h0, 1'b0);
        drv_d(1'b1, 8'h2, 32'hD2);
        cyc();
        drv_d(1'b0, 8'h0, 32'h0);
        chk("order_err_ooo", 64'(order_err), 1);
        chk("cnt_ooo", 64'(outstanding), 1);
        cyc();
        chk("order_err_sticky", 64'(order_err), 1);

        // Reset mid-transaction discards tracking; a late response is unexpected.
        do_reset();
        drv_d(1'b1, 8'h7, 32'h35);
        #1;
        chk("d_forward_empty", 64'(h_rsp.d_valid), 1);
        cyc();
        drv_d(1'b0, 8'h0, 32'h0);
        chk("order_err_empty", 64'(order_err), 1);
        chk("cnt_empty_resp", 64'(outstanding), 0);

        // Response with nothing outstanding in the same cycle as a request.
        do_reset();
        drv_a(1'b1, 8'h9, 1'b1);
        drv_d(1'b1, 8'h9, 32'h99);
        cyc();
        drv_a(1'b0, 8'h0, 1'b0);
        drv_d(1'b0, 8'h0, 32'h0);
        chk("order_err_empty_simul", 64'(order_err), 1);
        chk("cnt_empty_simul", 64'(outstanding), 0);

        // Idle timeout: a response at idle count 6 restarts it; then it fires.
        do_reset();
        drv_a(1'b1, 8'h3, 1'b1);
        cyc();
        drv_a(1'b1, 8'h4, 1'b1);
        cyc();
        drv_a(1'b0, 8'h0, 1'b0);
        repeat (5) cyc();
        chk("timeout_pre_resp", 64'(timeout), 0);
        drv_d(1'b1, 8'h3, 32'hE3);
        cyc();
        drv_d(1'b0, 8'h0, 32'h0);
        chk("timeout_after_resp", 64'(timeout), 0);
        chk("cnt_timeout_one", 64'(outstanding), 1);
        repeat (6) cyc();
        chk("timeout_edge_minus1", 64'(timeout), 0);
        cyc();
        chk("timeout_fire", 64'(timeout), 64'(TMO_EN));
        drv_d(1'b1, 8'h4, 32'hE4);
        cyc();
        drv_d(1'b0, 8'h0, 32'h0);
        repeat (2) cyc();
        chk("timeout_sticky", 64'(timeout), 64'(TMO_EN));
        chk("cnt_final", 64'(outstanding), 0);
        chk("order_ok_timeout_seq", 64'(order_err), 0);

        chk("exp_a_drained", 64'(exp_a.size()), 0);
        chk("exp_d_drained", 64'(exp_d.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tlul_req_limiter.md
TLUL_REQ_LIMITER -- requirements
Module: tlul_req_limiter

Interface
REQ-001 Parameter MaxOut, default 4: maximum outstanding A-channel requests; legal range 1..16.
REQ-002 Parameter TimeoutCycles, default 1024: D-channel inactivity limit in cycles; legal range 2..65535.
REQ-003 Localparam CntW = $clog2(MaxOut+1).
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 tl_h_i  input  tlul_pkg::tl_h2d_t  host-side request; typically the device port of the M:1 socket.
REQ-007 tl_h_o  output  tlul_pkg::tl_d2h_t  host-side response.
REQ-008 tl_d_o  output  tlul_pkg::tl_h2d_t  device-side request.
REQ-009 tl_d_i  input  tlul_pkg::tl_d2h_t  device-side response.
REQ-010 outstanding_o  output  CntW  current count of outstanding requests.
REQ-011 order_err_o  output  1  sticky flag: out-of-order or unexpected response.
REQ-012 timeout_o  output  1  sticky flag: D-channel inactivity timeout.

Function
REQ-013 full = (outstanding_o == MaxOut).
REQ-014 tl_d_o SHALL equal tl_h_i in all fields, except tl_d_o.a_valid = tl_h_i.a_valid & ~full.
REQ-015 tl_h_o SHALL equal tl_d_i in all fields, except tl_h_o.a_ready = tl_d_i.a_ready & ~full.
REQ-016 Both paths SHALL be combinational, with zero cycles of added latency.
REQ-017 A-accept = tl_d_o.a_valid & tl_d_i.a_ready.
REQ-018 D-accept = tl_d_i.d_valid & tl_h_i.d_ready.
REQ-019 Counter update: +1 on A-accept only; -1 on D-accept only when nonzero; unchanged on simultaneous A-accept and D-accept.
REQ-020 The counter SHALL never exceed MaxOut and SHALL never wrap below 0.
REQ-021 Source FIFO: depth MaxOut, width top_pkg::TL_AIW.
  - Push a_source on A-accept.
  - Pop on D-accept when nonempty.
  - Simultaneous push and pop are both honoured.
  - FIFO occupancy SHALL always equal outstanding_o.
REQ-022 On D-accept with a nonempty FIFO and d_source != FIFO head, order_err_o SHALL set on the next edge; the pop still occurs.
REQ-023 On D-accept with an empty FIFO (including an A-accept in the same cycle), order_err_o SHALL set and the counter SHALL stay unchanged.
REQ-024 order_err_o and timeout_o SHALL clear only on reset.
REQ-025 The block SHALL never drop, alter or fabricate a D-channel beat; errors are flagged only.

Reset
REQ-026 Reset asserted: outstanding_o=0, FIFO empty, order_err_o=0, timeout_o=0, timeout counter=0.
REQ-027 Reset mid-transaction SHALL discard all tracking state; responses arriving after reset release are treated per REQ-023.
REQ-028 Combinational outputs SHALL follow their inputs during reset, with full=0.

Configuration
REQ-029 Macro TLUL_REQ_LIMITER_TIMEOUT_EN defined:
  - A 16-bit idle counter increments each cycle while outstanding_o != 0 and no D-accept occurs.
  - It clears on any D-accept or when outstanding_o == 0.
  - timeout_o sets on the edge where the counter reaches TimeoutCycles-1, and stays set.
REQ-030 Macro TLUL_REQ_LIMITER_TIMEOUT_EN undefined: no idle counter is instantiated, and timeout_o is tied to 0.

Verification
REQ-031 MaxOut=4, device a_ready=1 and d_valid=0: 6 back-to-back host requests -> 4 accepted, outstanding_o=4, then host a_ready=0 and tl_d_o.a_valid=0.
REQ-032 Full at 4, one D-accept with a matching source -> outstanding_o=3 next cycle, and the next request passes the same cycle.
REQ-033 Count=2, A-accept and D-accept in the same cycle -> outstanding_o stays 2, FIFO advances, order_err_o=0.
REQ-034 Sources 0x1, 0x2 issued, response d_source=0x2 first -> order_err_o=1 next cycle, outstanding_o=1.
REQ-035 Response with count=0 -> order_err_o=1, outstanding_o stays 0, beat still forwarded to the host.
REQ-036 TLUL_REQ_LIMITER_TIMEOUT_EN, TimeoutCycles=8, one outstanding request and no response -> timeout_o=1 after 8 cycles; a response at cycle 7 keeps it 0. Without the macro, timeout_o stays 0.
